// File: rtl/mips_bridge_n.sv
// System bridge between the MIPS data port, data memory and NUM_DEV device slots.
// Device accesses stall the CPU until the slot acknowledges or the timeout expires.
module mips_bridge_n #(
  parameter int unsigned NUM_DEV  = 2,
  parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
  parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV_SPAN = 32'h10,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_byteen,
  input  logic                    cpu_re,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  output logic                    cpu_err,
  output logic [31:0]             m_data_addr,
  output logic [31:0]             m_data_wdata,
  output logic [3:0]              m_data_byteen,
  input  logic [31:0]             m_data_rdata,
  output logic [31:0]             dev_addr,
  output logic [31:0]             dev_wdata,
  output logic [NUM_DEV-1:0]      dev_we,
  output logic [NUM_DEV-1:0]      dev_re,
  input  logic [32*NUM_DEV-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]      dev_ready,
  input  logic [NUM_DEV-1:0]      dev_irq,
  output logic [NUM_DEV-1:0]      hw_int
);

  localparam int unsigned SPAN_SH = $clog2(DEV_SPAN);
  localparam int unsigned SEL_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

  state_t             state, state_next;
  logic [31:0]        lat_addr, lat_wdata, rdata_q;
  logic [SEL_W-1:0]   lat_sel, dec_sel;
  logic               lat_we;
  logic [CNT_W-1:0]   cnt;
  logic               start, capture, cnt_inc;

  logic [31:0]        dev_off, slot_idx;
  logic               is_store, req, dm_hit, dev_hit, dev_legal;
  logic [31:0]        slot_rdata [NUM_DEV];
  logic               sel_ready;
  logic [NUM_DEV-1:0] sel_mask;

  // Address decode: data memory has priority over the device window
  always_comb begin
    is_store  = |cpu_byteen;
    req       = cpu_re | is_store;
    dm_hit    = cpu_addr < DM_LIMIT;
    dev_off   = cpu_addr - DEV_BASE;
    slot_idx  = dev_off >> SPAN_SH;
    dev_hit   = !dm_hit && (cpu_addr >= DEV_BASE) && (slot_idx < 32'(NUM_DEV));
    dec_sel   = slot_idx[SEL_W-1:0];
    dev_legal = dev_hit && (!is_store || cpu_byteen == 4'b1111);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      slot_rdata[i] = dev_rdata[32*i +: 32];
    end
    sel_ready = dev_ready[lat_sel];
    sel_mask  = NUM_DEV'(1) << lat_sel;
  end

  always_comb begin
    state_next    = state;
    cpu_stall     = 1'b0;
    cpu_err       = 1'b0;
    cpu_rdata     = '0;
    m_data_byteen = '0;
    dev_we        = '0;
    dev_re        = '0;
    start         = 1'b0;
    capture       = 1'b0;
    cnt_inc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_hit) begin
          m_data_byteen = cpu_byteen;
          cpu_rdata     = m_data_rdata;
        end else if (req) begin
          if (dev_legal) begin
            cpu_stall  = 1'b1;
            start      = 1'b1;
            state_next = WAIT;
          end else begin
            cpu_err = 1'b1;
          end
        end
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (lat_we) dev_we = sel_mask;
        else        dev_re = sel_mask;
        if (sel_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          state_next = ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        cpu_rdata  = rdata_q;
        state_next = IDLE;
      end
      ERR: begin
        cpu_err    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      hw_int    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
      lat_we    <= 1'b0;
    end else begin
      state  <= state_next;
      hw_int <= dev_irq;
      if (start) begin
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        lat_sel   <= dec_sel;
        lat_we    <= is_store;
        cnt       <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) rdata_q <= lat_we ? '0 : slot_rdata[lat_sel];
    end
  end

  assign m_data_addr  = cpu_addr;
  assign m_data_wdata = cpu_wdata;
  assign dev_addr     = lat_addr;
  assign dev_wdata    = lat_wdata;

endmodule

// File: tb/tb_mips_bridge_n.sv
// Directed scoreboard bench for mips_bridge_n: DM, device, error, timeout, reset and interrupt paths.
module tb_mips_bridge_n;

  localparam int NUM_DEV = 2;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_re, cpu_stall, cpu_err;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] dev_addr, dev_wdata;
  logic [NUM_DEV-1:0] dev_we, dev_re, dev_ready, dev_irq, hw_int;
  logic [32*NUM_DEV-1:0] dev_rdata;

  mips_bridge_n #(
    .NUM_DEV (NUM_DEV),
    .DM_LIMIT(32'h0000_3000),
    .DEV_BASE(32'h0000_7F00),
    .DEV_SPAN(32'h10),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_byteen   (cpu_byteen),
    .cpu_re       (cpu_re),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_err      (cpu_err),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_data_rdata (m_data_rdata),
    .dev_addr     (dev_addr),
    .dev_wdata    (dev_wdata),
    .dev_we       (dev_we),
    .dev_re       (dev_re),
    .dev_rdata    (dev_rdata),
    .dev_ready    (dev_ready),
    .dev_irq      (dev_irq),
    .hw_int       (hw_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access; expectation is queued at drive time and popped on the response cycle.
  // ready_at = WAIT cycle (1-based) in which the selected slot acks, -1 = never.
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic re, input int ready_at,
                        input logic [31:0] rd, input logic other_rdy,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_stalls,
                        input logic [3:0] exp_mbe, input logic [1:0] exp_we, input logic [1:0] exp_re);
    exp_t got;
    logic [1:0] sel_mask, other;
    int stalls;
    bit done;
    sel_mask = exp_we | exp_re;
    other    = other_rdy ? ~sel_mask : 2'b00;
    @(posedge clk); #1;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    cpu_byteen   = be;
    cpu_re       = re;
    m_data_rdata = rd;
    dev_rdata    = (sel_mask == 2'b10) ? {rd, ~rd} : {~rd, rd};
    sb.push_back('{exp_rdata, exp_err, exp_stalls});
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      dev_ready = other | ((c == ready_at) ? sel_mask : 2'b00);
      @(negedge clk);
      if (cpu_stall) begin
        stalls++;
        if (c > 0) begin
          chk({tag, "_we"}, dev_we, exp_we);
          chk({tag, "_re"}, dev_re, exp_re);
          chk({tag, "_daddr"}, dev_addr, addr);
          if (exp_we != 2'b00) chk({tag, "_dwdata"}, dev_wdata, wdata);
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) chk({tag, "_stall_bound"}, cpu_stall, 0);
    got = sb.pop_front();
    chk({tag, "_rdata"}, cpu_rdata, got.rdata);
    chk({tag, "_err"}, cpu_err, got.err);
    chk({tag, "_stalls"}, stalls, got.stalls);
    chk({tag, "_mbe"}, m_data_byteen, exp_mbe);
    chk({tag, "_maddr"}, m_data_addr, addr);
    chk({tag, "_resp_strobes"}, {dev_we, dev_re}, 0);
    @(posedge clk); #1;
    cpu_re     = 1'b0;
    cpu_byteen = 4'h0;
    dev_ready  = 2'b00;
    @(negedge clk);
    chk({tag, "_after_stall"}, cpu_stall, 0);
    chk({tag, "_after_err"}, cpu_err, 0);
    chk({tag, "_after_strobes"}, {dev_we, dev_re}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0; cpu_re = 1'b0;
    m_data_rdata = '0; dev_rdata = '0; dev_ready = '0; dev_irq = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_strobes", {dev_we, dev_re}, 0);
    chk("rst_hw_int", hw_int, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mbe", m_data_byteen, 0);

    //      tag         addr          wdata         be     re  rdy  rd            oth  exp_rd        err  stl  mbe   we     re
    access("dm_sw",     32'h0000_1004, 32'hDEADBEEF, 4'hF, 0, -1, 32'h0,        0, 32'h0,        0,  0, 4'hF, 2'b00, 2'b00);
    access("dm_lw",     32'h0000_1004, 32'h0,        4'h0, 1, -1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0,  0, 4'h0, 2'b00, 2'b00);
    access("dm_edge",   32'h0000_2FFC, 32'h0,        4'h0, 1, -1, 32'h5555AAAA, 0, 32'h5555AAAA, 0,  0, 4'h0, 2'b00, 2'b00);
    access("dev_rd",    32'h0000_7F14, 32'h0,        4'h0, 1,  1, 32'h0000_1234, 0, 32'h0000_1234, 0, 2, 4'h0, 2'b00, 2'b10);
    access("dev_wr",    32'h0000_7F00, 32'h0000_00A5, 4'hF, 0, 3, 32'hFFFF_0000, 0, 32'h0,       0,  4, 4'h0, 2'b01, 2'b00);
    access("dev_ldst",  32'h0000_7F1C, 32'h0000_0077, 4'hF, 1, 1, 32'h0000_9999, 0, 32'h0,       0,  2, 4'h0, 2'b10, 2'b00);
    access("tmo",       32'h0000_7F08, 32'h0,        4'h0, 1, -1, 32'h0000_0BAD, 1, 32'h0,        1, 16, 4'h0, 2'b00, 2'b01);
    access("unmap",     32'h0000_5000, 32'h0,        4'h0, 1, -1, 32'h0000_1111, 0, 32'h0,        1,  0, 4'h0, 2'b00, 2'b00);
    access("unmap_hi",  32'h0000_7F20, 32'h0,        4'h0, 1, -1, 32'h0000_2222, 0, 32'h0,        1,  0, 4'h0, 2'b00, 2'b00);
    access("unmap_lo",  32'h0000_7EFC, 32'h0,        4'h0, 1, -1, 32'h0000_3333, 0, 32'h0,        1,  0, 4'h0, 2'b00, 2'b00);
    access("sb_dev",    32'h0000_7F10, 32'h0000_00AB, 4'h1, 0, -1, 32'h0,       0, 32'h0,        1,  0, 4'h0, 2'b00, 2'b00);

    // Reset during the second WAIT cycle, with an interrupt raised while reset is held
    @(posedge clk); #1;
    cpu_addr = 32'h0000_7F04; cpu_re = 1'b1; dev_ready = 2'b00;
    @(negedge clk);
    chk("rw_idle_stall", cpu_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_wait1_re", dev_re, 2'b01);
    @(posedge clk); #1;
    reset = 1'b1; cpu_re = 1'b0; dev_irq = 2'b10;
    @(negedge clk);
    chk("rw_wait2_re", dev_re, 2'b01);
    chk("rw_wait2_hw_int", hw_int, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_abort_stall", cpu_stall, 0);
    chk("rw_abort_strobes", {dev_we, dev_re}, 0);
    chk("rw_abort_err", cpu_err, 0);
    chk("rw_reset_hw_int", hw_int, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("irq_pre_hw_int", hw_int, 0);
    @(posedge clk); #1;
    dev_irq = 2'b00;
    @(negedge clk);
    chk("irq_hw_int", hw_int, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_clear_hw_int", hw_int, 0);

    access("post_rst_rd", 32'h0000_7F04, 32'h0, 4'h0, 1, 2, 32'h0000_ABCD, 0, 32'h0000_ABCD, 0, 3, 4'h0, 2'b00, 2'b01);
    access("post_rst_dm", 32'h0000_0000, 32'h0, 4'h0, 1, -1, 32'h0000_4444, 0, 32'h0000_4444, 0, 0, 4'h0, 2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
